spi_slave_bridge: RTL and testbench
===================================

Name: spi_slave_bridge

Overview:
- SPI slave front end: receives serial SPI frames (mode 0, MSB first) on external pins and produces byte-wide data for the downstream instruction decoder.
- Returns the decoder's read data serially on miso.
- Oversamples sclk/cs_n/mosi in the clk domain. No logic runs on sclk.
- Sits between the chip pins and the instruction decoder: feeds its byte_sync/data_in, consumes its data_out.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per async input (min 2).
- TIMEOUT_CYCLES, 1024, clk cycles of sclk inactivity that abort a partial byte (used only with the optional feature).

Ports:
- clk  input  1  peripheral clock; must be >= 6x sclk frequency.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock, async to clk, idles low.
- cs_n  input  1  SPI chip select, active-low, async.
- mosi  input  1  SPI serial data in, async.
- miso  output  1  SPI serial data out.
- byte_sync  output  1  one-clk pulse: data_rx holds a new complete byte.
- data_rx  output  8  last received byte (to decoder data_in).
- data_tx  input  8  byte to transmit (from decoder data_out).

Behaviour:
- Reset (async, rst_n low): byte_sync=0, data_rx=0x00, miso=0, bit_cnt=0, state=IDLE. Synchronizer chains reset to sclk=0, cs_n=1, mosi=0. Reset mid-transfer discards the partial byte; no byte_sync is emitted after release until 8 new rising edges occur.
- Synchronization: sclk, cs_n and mosi each pass SYNC_STAGES flops. Edge pulses sclk_rise and sclk_fall are formed from the last two sclk stages. mosi uses the same depth, so the sample stays aligned to the sclk edge.
- State IDLE (cs_n_s=1):
  - sclk edges are ignored; bit_cnt=0; miso=0.
  - On cs_n_s falling: tx_shift<=data_tx, miso<=data_tx[7], go to SHIFT.
- State SHIFT (cs_n_s=0):
  - On sclk_rise: rx_shift<={rx_shift[6:0],mosi_s}; bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
  - When bit_cnt==7 at a sclk_rise: data_rx<={rx_shift[6:0],mosi_s} in the same cycle and byte_sync=1 for exactly the next clk cycle. Latency from the 8th synced rising edge to the byte_sync assertion: 1 clk.
  - On sclk_fall with bit_cnt!=0: tx_shift<={tx_shift[6:0],1'b0}; miso<=tx_shift[6].
  - On sclk_fall with bit_cnt==0 (byte boundary): tx_shift<=data_tx; miso<=data_tx[7].
  - Reloading at this falling edge gives the decoder at least 2 clk after byte_sync to present read data on data_tx.
  - On cs_n_s rising: go to IDLE and discard any partial byte (no byte_sync). data_rx keeps its last value.
- Simultaneous events:
  - cs_n_s rising in the same cycle as sclk_rise: the deselect wins and the edge is ignored.
  - cs_n_s falling in the same cycle as an sclk edge: the edge is ignored (a mode-0 master never does this).
- data_rx changes only together with a byte_sync pulse.
- byte_sync is never asserted on two consecutive cycles.
- Back-to-back bytes within one cs_n frame are supported without limit.

Optional Feature:
- Macro SPI_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter counts clk cycles in SHIFT with bit_cnt!=0 and no sclk edge. Any sclk edge clears it.
  - On reaching TIMEOUT_CYCLES: bit_cnt<=0, rx_shift discarded, no byte_sync. The next sclk_fall reloads tx_shift from data_tx.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). The counter resets to 0.
- Not defined: no counter exists; a partial byte persists until cs_n deasserts.

Decomposition:
- Package spi_pkg holds:
  - state encoding (IDLE, SHIFT)
  - BYTE_W=8, BIT_CNT_W=3
  - default SYNC_STAGES
- One sub-module, spi_sync_edge (synchronizer plus rise/fall pulse generator), instantiated for sclk and cs_n.
- mosi uses a plain synchronizer chain inside the top module.

Test Plan:
- Write frame: cs_n low, send 0x85 then 0xA5 at clk/8 -> two byte_sync pulses; data_rx=0x85 then 0xA5; each pulse exactly 1 clk wide.
- Read return: data_tx=0x3C before cs_n falls, clock 8 bits -> miso samples on rising edges = 0,0,1,1,1,1,0,0.
- Byte-boundary reload: first byte 0x12; change data_tx to 0xC3 within 1 clk after byte_sync -> second byte on miso = 0xC3.
- Abort: cs_n high after 5 bits, then a new frame sending 0x7E -> exactly one byte_sync, with data_rx=0x7E; no stale bits.
- Reset mid-byte: rst_n low after 3 bits -> all outputs 0 immediately; after release, a full byte 0x5A produces byte_sync with data_rx=0x5A.
- (SPI_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=64): 4 bits, sclk idle 100 clk, then 8 bits 0x99 -> single byte_sync, data_rx=0x99.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave bridge: state encoding,
// byte/bit-counter widths and the default synchronizer depth.
package spi_pkg;

  localparam int BYTE_W          = 8;
  localparam int BIT_CNT_W       = 3;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus single-cycle
// rise/fall pulses derived from the two oldest synchronizer stages.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  // Index 0 is the newest sample, STAGES-1 the oldest.
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule : spi_sync_edge

// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave front end, fully oversampled in the clk domain.
// Optional sclk-inactivity abort of a partial byte: define SPI_BRIDGE_TIMEOUT_EN.
module spi_slave_bridge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              byte_sync,
  output logic [BYTE_W-1:0] data_rx,
  input  logic [BYTE_W-1:0] data_tx
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(cs_n),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // mosi gets the same depth as sclk so its sample stays tied to the edge.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_d;
  logic                   mosi_s;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e           state_q,     state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [BYTE_W-1:0]    rx_shift_q,  rx_shift_d;
  logic [BYTE_W-1:0]    tx_shift_q,  tx_shift_d;
  logic [BYTE_W-1:0]    data_rx_q,   data_rx_d;
  logic                 miso_q,      miso_d;
  logic                 byte_sync_q, byte_sync_d;
  logic [BYTE_W-1:0]    rx_next;
  logic                 to_expire;

  assign rx_next = {rx_shift_q[BYTE_W-2:0], mosi_s};

`ifdef SPI_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts only idle cycles inside a partial byte; any sclk edge restarts it.
  always_comb begin
    to_cnt_d  = '0;
    to_expire = 1'b0;
    if (state_q == SHIFT && !cs_rise && !sclk_rise && !sclk_fall &&
        bit_cnt_q != '0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
        to_expire = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    data_rx_d   = data_rx_q;
    byte_sync_d = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        if (cs_fall) begin
          tx_shift_d = data_tx;
          miso_d     = data_tx[BYTE_W-1];
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        // Deselect has priority over a coincident sclk edge.
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_d     = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
            data_rx_d   = rx_next;
            byte_sync_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
            miso_d     = tx_shift_q[BYTE_W-2];
          end else begin
            // Byte boundary: pick up the decoder's freshly presented data.
            tx_shift_d = data_tx;
            miso_d     = data_tx[BYTE_W-1];
          end
        end else if (to_expire) begin
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      data_rx_q   <= '0;
      miso_q      <= 1'b0;
      byte_sync_q <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      data_rx_q   <= data_rx_d;
      miso_q      <= miso_d;
      byte_sync_q <= byte_sync_d;
    end
  end

  assign miso      = miso_q;
  assign byte_sync = byte_sync_q;
  assign data_rx   = data_rx_q;

endmodule : spi_slave_bridge

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: single-byte frame table plus
// hand-written multi-byte, reload, abort, reset and idle-gap sequences.
module tb_spi_slave_bridge;

  localparam int CLK_P = 10;
  localparam int HALF  = 40;  // sclk = clk/8

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_rx;
  logic [7:0] data_tx;

  spi_slave_bridge #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .byte_sync(byte_sync),
    .data_rx  (data_rx),
    .data_tx  (data_tx)
  );

  always #(CLK_P / 2) clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Byte-sync monitor, sampling on the falling clk edge.
  logic [7:0] rx_log[$];
  int         sync_cnt   = 0;
  int         width_err  = 0;
  int         change_err = 0;
  logic       sync_prev  = 1'b0;
  logic [7:0] rx_prev    = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_sync) begin
        rx_log.push_back(data_rx);
        sync_cnt++;
        if (sync_prev) width_err++;
      end
      if (data_rx !== rx_prev && !byte_sync) change_err++;
    end
    sync_prev = byte_sync;
    rx_prev   = data_rx;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #(HALF);
    m    = miso;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      logic m;
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  function automatic logic [7:0] logged(input int idx);
    return (idx < sync_cnt) ? rx_log[idx] : 8'hxx;
  endfunction

  typedef struct {
    logic [7:0] mosi_byte;
    logic [7:0] tx_byte;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  logic reload_seen;

  initial begin
    logic [7:0] m1;
    logic [7:0] m2;
    logic       mb;
    int         base;

    vecs[0] = '{8'h85, 8'h3C, 8'h85, 8'h3C};  // miso 0,0,1,1,1,1,0,0
    vecs[1] = '{8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{8'hFF, 8'h81, 8'hFF, 8'h81};
    vecs[4] = '{8'h5A, 8'hA5, 8'h5A, 8'hA5};

    rst_n   = 1'b0;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    data_tx = 8'h00;
    #23;
    check("reset_byte_sync", 32'(byte_sync), 32'h0);
    check("reset_data_rx",   32'(data_rx),   32'h00);
    check("reset_miso",      32'(miso),      32'h0);
    rst_n = 1'b1;
    #(5 * CLK_P);

    // Single-byte frames from the table.
    for (int i = 0; i < 5; i++) begin
      data_tx = vecs[i].tx_byte;
      base    = sync_cnt;
      cs_n    = 1'b0;
      #(HALF);
      spi_byte(vecs[i].mosi_byte, m1);
      #(HALF);
      cs_n = 1'b1;
      #(10 * CLK_P);
      check($sformatf("vec%0d_sync_count", i), 32'(sync_cnt - base), 32'd1);
      check($sformatf("vec%0d_data_rx", i),    32'(logged(base)),     32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_miso", i),       32'(m1),               32'(vecs[i].exp_miso));
      check($sformatf("vec%0d_miso_idle", i),  32'(miso),             32'h0);
    end

    // Two bytes back to back in one frame.
    base = sync_cnt;
    cs_n = 1'b0;
    #(HALF);
    spi_byte(8'h85, m1);
    spi_byte(8'hA5, m2);
    #(HALF);
    cs_n = 1'b1;
    #(10 * CLK_P);
    check("b2b_sync_count", 32'(sync_cnt - base),    32'd2);
    check("b2b_first",      32'(logged(base)),       32'h85);
    check("b2b_second",     32'(logged(base + 1)),   32'hA5);

    // Decoder updates data_tx right after the first byte_sync.
    data_tx     = 8'h12;
    reload_seen = 1'b0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (byte_sync) begin
            data_tx     = 8'hC3;
            reload_seen = 1'b1;
            break;
          end
        end
      end
    join_none
    cs_n = 1'b0;
    #(HALF);
    spi_byte(8'h00, m1);
    spi_byte(8'h00, m2);
    #(HALF);
    cs_n = 1'b1;
    #(10 * CLK_P);
    check("reload_sync_seen", 32'(reload_seen), 32'h1);
    check("reload_first",     32'(m1),          32'h12);
    check("reload_second",    32'(m2),          32'hC3);

    // Abort after 5 bits, then a clean frame.
    base = sync_cnt;
    cs_n = 1'b0;
    #(HALF);
    for (int k = 0; k < 5; k++) spi_bit(1'b1, mb);
    #(HALF);
    cs_n = 1'b1;
    #(10 * CLK_P);
    check("abort_no_sync", 32'(sync_cnt - base), 32'd0);
    cs_n = 1'b0;
    #(HALF);
    spi_byte(8'h7E, m1);
    #(HALF);
    cs_n = 1'b1;
    #(10 * CLK_P);
    check("abort_sync_count", 32'(sync_cnt - base), 32'd1);
    check("abort_data_rx",    32'(logged(base)),    32'h7E);

    // Reset in the middle of a byte with cs_n held low.
    data_tx = 8'hF0;
    cs_n    = 1'b0;
    #(HALF);
    for (int k = 0; k < 3; k++) spi_bit(1'b1, mb);
    #7;
    rst_n = 1'b0;
    #1;
    check("midrst_byte_sync", 32'(byte_sync), 32'h0);
    check("midrst_data_rx",   32'(data_rx),   32'h00);
    check("midrst_miso",      32'(miso),      32'h0);
    #30;
    rst_n = 1'b1;
    #(4 * CLK_P);
    base = sync_cnt;
    spi_byte(8'h5A, m1);
    #(HALF);
    cs_n = 1'b1;
    #(10 * CLK_P);
    check("midrst_sync_count", 32'(sync_cnt - base), 32'd1);
    check("midrst_data_rx2",   32'(logged(base)),    32'h5A);
    check("midrst_miso_byte",  32'(m1),              32'hF0);

    // 4 bits, 100 clk of sclk inactivity, then 0x99, all in one frame.
    base = sync_cnt;
    cs_n = 1'b0;
    #(HALF);
    for (int k = 0; k < 4; k++) spi_bit(1'b1, mb);
    #(100 * CLK_P);
    spi_byte(8'h99, m1);
    #(HALF);
    cs_n = 1'b1;
    #(10 * CLK_P);
    check("gap_sync_count", 32'(sync_cnt - base), 32'd1);
`ifdef SPI_BRIDGE_TIMEOUT_EN
    check("gap_data_rx", 32'(logged(base)), 32'h99);
`else
    // Partial byte persists: 1111 followed by the first four bits of 0x99.
    check("gap_data_rx", 32'(logged(base)), 32'hF9);
`endif

    check("byte_sync_width_errors", 32'(width_err),  32'd0);
    check("data_rx_change_errors",  32'(change_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spi_slave_bridge
